// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking neuron fabric.
// Helpers work at a fixed 32-bit width, which covers POT_W + sum width for practical builds.
package snn_pkg;

   typedef enum logic {
      INTEGRATE = 1'b0,
      REFRAC    = 1'b1
   } neuron_state_t;

   localparam int ACC_W = 32;
   typedef logic signed [ACC_W-1:0] acc_t;

   function automatic acc_t sat_add(input acc_t a, input acc_t b,
                                    input acc_t lo, input acc_t hi);
      acc_t s;
      s = a + b;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

   // Moves p toward zero by at most amt; never crosses zero.
   function automatic acc_t leak(input acc_t p, input acc_t amt);
      if (p > 0) return (p > amt) ? (p - amt) : '0;
      if (p < 0) return (-p > amt) ? (p + amt) : '0;
      return '0;
   endfunction

endpackage

// File: rtl/syn_weight_sum.sv
// Masked signed weight summation: adds weight[i] for every set axon bit.
module syn_weight_sum #(
   parameter int NUM_SYN  = 4,
   parameter int WEIGHT_W = 4,
   localparam int SUM_W   = WEIGHT_W + $clog2(NUM_SYN) + 1
) (
   input  logic [NUM_SYN-1:0][WEIGHT_W-1:0] weight,
   input  logic [NUM_SYN-1:0]               axon,
   output logic signed [SUM_W-1:0]          sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_SYN; i++) begin
         if (axon[i]) sum = sum + SUM_W'($signed(weight[i]));
      end
   end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: writable weight bank, saturating leaky potential,
// one-cycle registered spike and a programmable refractory period.
module lif_neuron
   import snn_pkg::*;
#(
   parameter int NUM_SYN    = 4,
   parameter int WEIGHT_W   = 4,
   parameter int POT_W      = 8,
   parameter int THRESHOLD  = 100,
   parameter int LEAK       = 1,
   parameter int REFRACTORY = 3,
   localparam int ADDR_W    = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [WEIGHT_W-1:0] wr_data_i,
   input  logic [NUM_SYN-1:0]  axon_i,
   output logic                spike_o,
   output logic [POT_W-1:0]    potential_o,
   output logic                refrac_o
);

   localparam int   SUM_W   = WEIGHT_W + $clog2(NUM_SYN) + 1;
   localparam int   CNT_W   = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
   localparam acc_t POT_MAX = (acc_t'(1) <<< (POT_W - 1)) - acc_t'(1);
   localparam acc_t POT_MIN = -(acc_t'(1) <<< (POT_W - 1));

   // No handshake: axon_i and the write port are sampled at every rising edge.
   logic [NUM_SYN-1:0][WEIGHT_W-1:0] weight_q;
   logic signed [SUM_W-1:0]          syn_sum;

   neuron_state_t           state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [POT_W-1:0] pot_q, pot_d;
   logic                    spike_q, spike_d;
   acc_t                    cand;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         weight_q <= '0;
      end else if (wr_en_i && (32'(wr_addr_i) < NUM_SYN)) begin
         weight_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Reads the pre-write bank, so a same-edge write only affects later cycles.
   syn_weight_sum #(
      .NUM_SYN (NUM_SYN),
      .WEIGHT_W(WEIGHT_W)
   ) u_sum (
      .weight(weight_q),
      .axon  (axon_i),
      .sum   (syn_sum)
   );

   assign cand = sat_add(leak(acc_t'(pot_q), acc_t'(LEAK)), acc_t'(syn_sum), POT_MIN, POT_MAX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= INTEGRATE;
         cnt_q   <= '0;
         pot_q   <= '0;
         spike_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pot_q   <= pot_d;
         spike_q <= spike_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pot_d   = pot_q;
      spike_d = 1'b0;
      case (state_q)
         INTEGRATE: begin
            if (cand >= acc_t'(THRESHOLD)) begin
               pot_d   = '0;
               spike_d = 1'b1;
               if (REFRACTORY > 0) begin
                  state_d = REFRAC;
                  cnt_d   = CNT_W'(REFRACTORY);
               end
            end else begin
               pot_d = cand[POT_W-1:0];
            end
         end
         REFRAC: begin
            // Axons ignored and no leak; potential parked at zero until the count expires.
            pot_d = '0;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = INTEGRATE;
         end
         default: state_d = INTEGRATE;
      endcase
   end

   assign spike_o     = spike_q;
   assign potential_o = pot_q;
   assign refrac_o    = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default build plus a REFRACTORY=0 / THRESHOLD=20 build.
module tb_lif_neuron;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       wr_en_i = 1'b0;
   logic [1:0] wr_addr_i = '0;
   logic [3:0] wr_data_i = '0;
   logic [3:0] axon_i = '0;

   logic       spike_a, refrac_a, spike_b, refrac_b;
   logic [7:0] pot_a, pot_b;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   lif_neuron dut_a (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .axon_i     (axon_i),
      .spike_o    (spike_a),
      .potential_o(pot_a),
      .refrac_o   (refrac_a)
   );

   lif_neuron #(
      .THRESHOLD (20),
      .REFRACTORY(0)
   ) dut_b (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .axon_i     (axon_i),
      .spike_o    (spike_b),
      .potential_o(pot_b),
      .refrac_o   (refrac_b)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      axon_i  = '0;
      wr_en_i = 1'b0;
      rst_i   = 1'b1;
      tick();
      rst_i   = 1'b0;
   endtask

   task automatic write_weight(input logic [1:0] addr, input logic [3:0] data);
      wr_en_i   = 1'b1;
      wr_addr_i = addr;
      wr_data_i = data;
      tick();
      wr_en_i   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) write_weight(2'(i), 4'd7);
      axon_i = 4'hF;
      tick();
      tick();
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (pot_a !== 8'd0) begin
         errors++;
         $display("FAIL reset_pot: got %0d expected 0", $signed(pot_a));
      end
      checks++;
      if (spike_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_spike: got %b expected 0", spike_a);
      end
      checks++;
      if (refrac_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_refrac: got %b expected 0", refrac_a);
      end
      #1 rst_i = 1'b0;
      tick();
      checks++;
      if (pot_a !== 8'd0) begin
         errors++;
         $display("FAIL reset_weights_zero: got %0d expected 0", $signed(pot_a));
      end
      axon_i = '0;
   endtask

   task automatic test_fire();
      int   exp_pot [8];
      logic exp_spk [8];
      logic exp_ref [8];
      exp_pot = '{28, 55, 82, 0, 0, 0, 0, 28};
      exp_spk = '{0, 0, 0, 1, 0, 0, 0, 0};
      exp_ref = '{0, 0, 0, 1, 1, 1, 0, 0};
      do_reset();
      for (int i = 0; i < 4; i++) write_weight(2'(i), 4'd7);
      axon_i = 4'hF;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ($signed(pot_a) !== 8'(exp_pot[i])) begin
            errors++;
            $display("FAIL fire_pot[%0d]: got %0d expected %0d", i, $signed(pot_a), exp_pot[i]);
         end
         checks++;
         if (spike_a !== exp_spk[i]) begin
            errors++;
            $display("FAIL fire_spike[%0d]: got %b expected %b", i, spike_a, exp_spk[i]);
         end
         checks++;
         if (refrac_a !== exp_ref[i]) begin
            errors++;
            $display("FAIL fire_refrac[%0d]: got %b expected %b", i, refrac_a, exp_ref[i]);
         end
      end
      axon_i = '0;
   endtask

   task automatic test_leak();
      int exp_pot [7];
      exp_pot = '{5, 4, 3, 2, 1, 0, 0};
      do_reset();
      write_weight(2'd0, 4'd5);
      axon_i = 4'b0001;
      for (int i = 0; i < 7; i++) begin
         tick();
         axon_i = '0;
         checks++;
         if ($signed(pot_a) !== 8'(exp_pot[i])) begin
            errors++;
            $display("FAIL leak_pot[%0d]: got %0d expected %0d", i, $signed(pot_a), exp_pot[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int exp_pot [8];
      exp_pot = '{-32, -63, -94, -125, -128, -128, -127, -126};
      do_reset();
      for (int i = 0; i < 4; i++) write_weight(2'(i), 4'h8);
      for (int i = 0; i < 8; i++) begin
         axon_i = (i < 6) ? 4'hF : 4'h0;
         tick();
         checks++;
         if ($signed(pot_a) !== 8'(exp_pot[i])) begin
            errors++;
            $display("FAIL sat_pot[%0d]: got %0d expected %0d", i, $signed(pot_a), exp_pot[i]);
         end
         checks++;
         if (spike_a !== 1'b0) begin
            errors++;
            $display("FAIL sat_spike[%0d]: got %b expected 0", i, spike_a);
         end
      end
      axon_i = '0;
   endtask

   task automatic test_collision();
      do_reset();
      write_weight(2'd1, 4'd2);
      wr_en_i   = 1'b1;
      wr_addr_i = 2'd1;
      wr_data_i = 4'd6;
      axon_i    = 4'b0010;
      tick();
      wr_en_i = 1'b0;
      checks++;
      if ($signed(pot_a) !== 8'sd2) begin
         errors++;
         $display("FAIL collision_old_weight: got %0d expected 2", $signed(pot_a));
      end
      tick();
      checks++;
      if ($signed(pot_a) !== 8'sd7) begin
         errors++;
         $display("FAIL collision_new_weight: got %0d expected 7", $signed(pot_a));
      end
      axon_i = '0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) write_weight(2'(i), 4'd7);
      axon_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (spike_b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_spike[%0d]: got %b expected 1", i, spike_b);
         end
         checks++;
         if (refrac_b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_refrac[%0d]: got %b expected 0", i, refrac_b);
         end
         checks++;
         if (pot_b !== 8'd0) begin
            errors++;
            $display("FAIL b2b_pot[%0d]: got %0d expected 0", i, $signed(pot_b));
         end
      end
      axon_i = '0;
   endtask

   initial begin
      test_reset();
      test_fire();
      test_leak();
      test_saturation();
      test_collision();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
